// File: rtl/tick_interval_timer.sv
// Interval timer fed by the clock divider's toggling IncCounter level: every
// level change is one tick, and the block counts down a loaded number of ticks.
module tick_interval_timer #(
    parameter int CNT_W = 8,
    parameter int ST_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start,
    input  logic [CNT_W-1:0] duration,
    input  logic             pause,
    input  logic             cancel,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic             expired,
    output logic [ST_W-1:0]  state
);

    typedef enum logic [ST_W-1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               expired_q, expired_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick_q;
    logic               tick_evt;

    assign tick_evt = tick_in ^ tick_q;

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        expired_d   = expired_q;

        if (cancel) begin
            state_d     = IDLE;
            remaining_d = '0;
            expired_d   = 1'b0;
        end else if (start) begin
            if (duration != '0) begin
                state_d     = RUN;
                remaining_d = duration;
                expired_d   = 1'b0;
            end else begin
                state_d     = DONE;
                remaining_d = '0;
                expired_d   = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    // A tick arriving with pause is dropped, not carried into PAUSED.
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick_evt) begin
                        if (remaining_q > CNT_W'(1)) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end else begin
                            state_d     = DONE;
                            remaining_d = '0;
                            expired_d   = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) state_d = RUN;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSED);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q      <= 1'b0;
            state_q     <= IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tick_q      <= tick_in;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign remaining = remaining_q;
    assign done      = done_q;
    assign expired   = expired_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tick_interval_timer.sv
// Directed bench for tick_interval_timer; outputs are compared as one packed
// word {state, busy, done, expired, remaining} against hand-computed values.
module tb_tick_interval_timer;

    localparam int CNT_W = 8;
    localparam int ST_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick_in;
    logic             start;
    logic [CNT_W-1:0] duration;
    logic             pause;
    logic             cancel;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic             done;
    logic             expired;
    logic [ST_W-1:0]  state;

    logic [12:0] obs;
    logic [12:0] exp_v;
    int vectors = 0;
    int miscompares = 0;

    assign obs = {state, busy, done, expired, remaining};

    tick_interval_timer #(.CNT_W(CNT_W), .ST_W(ST_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .start     (start),
        .duration  (duration),
        .pause     (pause),
        .cancel    (cancel),
        .busy      (busy),
        .remaining (remaining),
        .done      (done),
        .expired   (expired),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle();
        tick_in = ~tick_in;
        cyc();
    endtask

    task automatic do_start(input logic [CNT_W-1:0] d);
        start    = 1'b1;
        duration = d;
        cyc();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_in = 1'b0; start = 1'b0; duration = '0;
        pause = 1'b0; cancel = 1'b0;
        #12;
        exp_v = {2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        do_start(8'd3);
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd3};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL basic_load: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            toggle();
            if (i < 2) exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'(2 - i)};
            else       exp_v = {2'd3, 1'b0, 1'b1, 1'b1, 8'd0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL basic_tick%0d: got %h expected %h", i, obs, exp_v);
            end
            // Spacing cycles: after the final tick, done must already be gone.
            for (int k = 0; k < 3; k++) begin
                cyc();
                if (i < 2) exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'(2 - i)};
                else       exp_v = {2'd0, 1'b0, 1'b0, 1'b1, 8'd0};
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL basic_hold%0d_%0d: got %h expected %h", i, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_zero_duration();
        do_start(8'd0);
        exp_v = {2'd3, 1'b0, 1'b1, 1'b1, 8'd0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL zero_done: got %h expected %h", obs, exp_v);
        end
        cyc();
        exp_v = {2'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL zero_after: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_pause();
        do_start(8'd5);
        toggle(); cyc();
        toggle(); cyc();
        pause = 1'b1;
        cyc();
        exp_v = {2'd2, 1'b1, 1'b0, 1'b0, 8'd3};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL pause_enter: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            toggle(); cyc();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pause_hold%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        pause = 1'b0;
        cyc();
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd3};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL pause_exit: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            toggle();
            if (i < 2) exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'(2 - i)};
            else       exp_v = {2'd3, 1'b0, 1'b1, 1'b1, 8'd0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pause_resume%0d: got %h expected %h", i, obs, exp_v);
            end
            cyc();
        end
    endtask

    task automatic test_pause_edges();
        do_start(8'd4);
        // Tick coincident with pause rising is discarded.
        pause = 1'b1;
        toggle();
        exp_v = {2'd2, 1'b1, 1'b0, 1'b0, 8'd4};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL pause_edge_in: got %h expected %h", obs, exp_v);
        end
        // Tick coincident with pause falling is discarded too.
        pause = 1'b0;
        toggle();
        cyc();
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd4};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL pause_edge_out: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_cancel();
        do_start(8'd4);
        toggle(); cyc();
        cancel = 1'b1; start = 1'b1; duration = 8'd9;
        cyc();
        cancel = 1'b0; start = 1'b0;
        exp_v = {2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL cancel_wins: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            toggle(); cyc();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL cancel_idle%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        // Cancel on the final tick suppresses done and expired.
        do_start(8'd1);
        cancel = 1'b1;
        toggle();
        cancel = 1'b0;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL cancel_final: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_restart();
        do_start(8'd10);
        for (int i = 0; i < 6; i++) begin
            toggle(); cyc();
        end
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd4};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL restart_mid: got %h expected %h", obs, exp_v);
        end
        do_start(8'd2);
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd2};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL restart_load: got %h expected %h", obs, exp_v);
        end
        toggle(); cyc();
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd1};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL restart_tick: got %h expected %h", obs, exp_v);
        end
        toggle();
        exp_v = {2'd3, 1'b0, 1'b1, 1'b1, 8'd0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL restart_done: got %h expected %h", obs, exp_v);
        end
        cyc();
    endtask

    task automatic test_max_duration();
        do_start(8'd255);
        toggle();
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd254};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL max_dur: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_async_reset();
        do_start(8'd7);
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd7};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL areset_pre: got %h expected %h", obs, exp_v);
        end
        #2 reset = 1'b1;
        #1;
        exp_v = {2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL areset_immediate: got %h expected %h", obs, exp_v);
        end
        cyc();
        reset = 1'b0;
        cyc();
        toggle(); cyc();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL areset_idle_tick: got %h expected %h", obs, exp_v);
        end
        do_start(8'd2);
        toggle();
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 8'd1};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL areset_restart: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_duration();
        test_pause();
        test_pause_edges();
        test_cancel();
        test_restart();
        test_max_duration();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
